// File: rtl/polyeval_pkg.sv
// rtl/polyeval_pkg.sv - constants and state encoding shared by the STP and EVP polynomial stages
package polyeval_pkg;

   localparam int MAX_DEGREE  = 10;
   localparam int COEFF_SLOTS = 11;
   localparam int NUM_POLY    = 8;

   localparam logic [31:0] STATUS_OK        = 32'd0;
   localparam logic [31:0] STATUS_INVALID_N = 32'd1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK_N   = 3'd1,
      S_WAIT_DATA = 3'd2,
      S_RD_DATA   = 3'd3,
      S_WR_COEFF  = 3'd4,
      S_WR_N      = 3'd5,
      S_DONE      = 3'd6,
      S_ERROR     = 3'd7
   } poly_state_t;

   // Slot base is slot*11; the largest address (7*11+10 = 87) fits in 7 bits.
   function automatic logic [6:0] coeff_addr(input logic [2:0] slot, input logic [3:0] idx);
      coeff_addr = 7'(slot) * 7'(COEFF_SLOTS) + 7'(idx);
   endfunction

endpackage

// File: rtl/stp_rd_ptr.sv
// rtl/stp_rd_ptr.sv - loadable read pointer that wraps modulo buffer_size
module stp_rd_ptr #(
   parameter int buffer_size = 1024,
   parameter int PTR_W       = 10
) (
   input  logic             clk,
   input  logic             i_load,
   input  logic [PTR_W-1:0] i_load_val,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   // Explicit compare so non-power-of-two depths also wrap correctly.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_ptr <= i_load_val;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == PTR_W'(buffer_size - 1)) ? '0 : r_ptr + PTR_W'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/stp_fsm.sv
// rtl/stp_fsm.sv - STP instruction FSM: copies N+1 coefficients from the data buffer into S[A*11..] and N into N[A]
// STP_CHECKSUM_EN: report a 16-bit wrap-around coefficient sum in status[31:16] on success
module stp_fsm
   import polyeval_pkg::*;
#(
   parameter int word_size   = 16,
   parameter int buffer_size = 1024,
   parameter int PTR_W       = $clog2(buffer_size)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rst_instr,
   input  logic                 start_stp,
   input  logic [2:0]           A,
   input  logic [4:0]           N_in,
   input  logic [PTR_W-1:0]     rd_addr_data,
   input  logic [PTR_W:0]       data_count,
   input  logic [word_size-1:0] data_in,
   output logic                 en_rd_data,
   output logic [PTR_W-1:0]     rd_addr_data_out,
   output logic [PTR_W-1:0]     rd_addr_data_updated,
   output logic                 en_wr_S,
   output logic [6:0]           wr_addr_S,
   output logic [word_size-1:0] wr_data_S,
   output logic                 en_wr_N,
   output logic [2:0]           wr_addr_N,
   output logic [4:0]           wr_data_N,
   output logic                 done_stp,
   output logic [31:0]          status
);

   poly_state_t r_state, w_state_nxt;

   logic [2:0]       r_a;
   logic [4:0]       r_n;
   logic [3:0]       r_i;
   logic             w_reset;
   logic             w_last;
   logic             w_ptr_inc;
   logic [PTR_W:0]   w_need;
   logic [PTR_W-1:0] w_ptr;
   logic [31:0]      w_status_ok;

   logic             w_en_rd_nxt, w_en_wr_s_nxt, w_en_wr_n_nxt, w_done_nxt;
   logic [PTR_W-1:0] w_rd_addr_nxt;
   logic [6:0]       w_wr_addr_s_nxt;
   logic [2:0]       w_wr_addr_n_nxt;
   logic [4:0]       w_wr_data_n_nxt;

   logic             r_en_rd, r_en_wr_s, r_en_wr_n, r_done;
   logic [PTR_W-1:0] r_rd_addr_out, r_rd_upd;
   logic [6:0]       r_wr_addr_s;
   logic [2:0]       r_wr_addr_n;
   logic [4:0]       r_wr_data_n;
   logic [31:0]      r_status;

   assign w_reset = rst | ~rst_instr;
   assign w_need  = (PTR_W+1)'(r_n) + (PTR_W+1)'(1);

   stp_rd_ptr #(
      .buffer_size (buffer_size),
      .PTR_W       (PTR_W)
   ) u_rd_ptr (
      .clk        (clk),
      .i_load     (w_reset | ((r_state == S_IDLE) & start_stp)),
      .i_load_val (rd_addr_data),
      .i_inc      (w_ptr_inc),
      .o_ptr      (w_ptr)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_inc   = 1'b0;
      w_last      = ({1'b0, r_i} == r_n);
      case (r_state)
         S_IDLE:      if (start_stp) w_state_nxt = S_CHECK_N;
         S_CHECK_N:   w_state_nxt = (r_n > 5'(MAX_DEGREE)) ? S_ERROR : S_WAIT_DATA;
         S_WAIT_DATA: if (data_count >= w_need) w_state_nxt = S_RD_DATA;
         S_RD_DATA: begin
            w_ptr_inc   = 1'b1;
            w_state_nxt = S_WR_COEFF;
         end
         S_WR_COEFF:  w_state_nxt = w_last ? S_WR_N : S_RD_DATA;
         S_WR_N:      w_state_nxt = S_DONE;
         S_DONE:      w_state_nxt = S_IDLE;
         S_ERROR:     w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase

      // Outputs are registered on entry so each strobe is high for exactly its state's cycle.
      w_en_rd_nxt     = (w_state_nxt == S_RD_DATA);
      w_rd_addr_nxt   = w_en_rd_nxt ? w_ptr : '0;
      w_en_wr_s_nxt   = (w_state_nxt == S_WR_COEFF);
      w_wr_addr_s_nxt = w_en_wr_s_nxt ? coeff_addr(r_a, r_i) : '0;
      w_en_wr_n_nxt   = (w_state_nxt == S_WR_N);
      w_wr_addr_n_nxt = w_en_wr_n_nxt ? r_a : '0;
      w_wr_data_n_nxt = w_en_wr_n_nxt ? r_n : '0;
      w_done_nxt      = (w_state_nxt == S_DONE) | (w_state_nxt == S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_state       <= S_IDLE;
         r_a           <= '0;
         r_n           <= '0;
         r_i           <= '0;
         r_en_rd       <= 1'b0;
         r_rd_addr_out <= '0;
         r_en_wr_s     <= 1'b0;
         r_wr_addr_s   <= '0;
         r_en_wr_n     <= 1'b0;
         r_wr_addr_n   <= '0;
         r_wr_data_n   <= '0;
         r_done        <= 1'b0;
         r_status      <= '0;
         r_rd_upd      <= rd_addr_data;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && start_stp) begin
            r_a <= A;
            r_n <= N_in;
            r_i <= '0;
         end else if ((r_state == S_WR_COEFF) && !w_last) begin
            r_i <= r_i + 4'd1;
         end
         r_en_rd       <= w_en_rd_nxt;
         r_rd_addr_out <= w_rd_addr_nxt;
         r_en_wr_s     <= w_en_wr_s_nxt;
         r_wr_addr_s   <= w_wr_addr_s_nxt;
         r_en_wr_n     <= w_en_wr_n_nxt;
         r_wr_addr_n   <= w_wr_addr_n_nxt;
         r_wr_data_n   <= w_wr_data_n_nxt;
         r_done        <= w_done_nxt;
         if (w_state_nxt == S_DONE) begin
            r_status <= w_status_ok;
            r_rd_upd <= w_ptr;
         end else if (w_state_nxt == S_ERROR) begin
            r_status <= STATUS_INVALID_N;
            r_rd_upd <= rd_addr_data;
         end
      end
   end

`ifdef STP_CHECKSUM_EN
   logic [15:0] r_csum;

   always_ff @(posedge clk) begin
      if (w_reset || (r_state == S_IDLE)) begin
         r_csum <= '0;
      end else if (r_state == S_WR_COEFF) begin
         r_csum <= r_csum + 16'(data_in);
      end
   end

   assign w_status_ok = {r_csum, 16'h0000};
`else
   assign w_status_ok = STATUS_OK;
`endif

   assign en_rd_data           = r_en_rd;
   assign rd_addr_data_out     = r_rd_addr_out;
   assign rd_addr_data_updated = r_rd_upd;
   assign en_wr_S              = r_en_wr_s;
   assign wr_addr_S            = r_wr_addr_s;
   // The buffer registers its read data, so it is forwarded during the write slot.
   assign wr_data_S            = r_en_wr_s ? data_in : '0;
   assign en_wr_N              = r_en_wr_n;
   assign wr_addr_N            = r_wr_addr_n;
   assign wr_data_N            = r_wr_data_n;
   assign done_stp             = r_done;
   assign status               = r_status;

endmodule

// File: tb/tb_stp_fsm.sv
// tb/tb_stp_fsm.sv - self-checking bench for stp_fsm against a transaction-level reference model
module tb_stp_fsm;

   localparam int WS = 16;
   localparam int BS = 1024;
   localparam int PW = 10;

   logic          clk = 1'b0;
   logic          rst, rst_instr, start_stp;
   logic [2:0]    A;
   logic [4:0]    N_in;
   logic [PW-1:0] rd_addr_data;
   logic [PW:0]   data_count;
   logic [WS-1:0] data_in = '0;
   logic          en_rd_data, en_wr_S, en_wr_N, done_stp;
   logic [PW-1:0] rd_addr_data_out, rd_addr_data_updated;
   logic [6:0]    wr_addr_S;
   logic [WS-1:0] wr_data_S;
   logic [2:0]    wr_addr_N;
   logic [4:0]    wr_data_N;
   logic [31:0]   status;

   always #5 clk = ~clk;

   stp_fsm #(.word_size(WS), .buffer_size(BS)) dut (
      .clk(clk), .rst(rst), .rst_instr(rst_instr), .start_stp(start_stp),
      .A(A), .N_in(N_in), .rd_addr_data(rd_addr_data), .data_count(data_count),
      .data_in(data_in), .en_rd_data(en_rd_data), .rd_addr_data_out(rd_addr_data_out),
      .rd_addr_data_updated(rd_addr_data_updated), .en_wr_S(en_wr_S), .wr_addr_S(wr_addr_S),
      .wr_data_S(wr_data_S), .en_wr_N(en_wr_N), .wr_addr_N(wr_addr_N), .wr_data_N(wr_data_N),
      .done_stp(done_stp), .status(status)
   );

   logic [WS-1:0] bufm [BS];
   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;
   int rd_q[$];
   int sw_q[$];
   int nw_q[$];

   // Data buffer (one-cycle read latency) plus recorders for every memory access.
   always @(posedge clk) begin
      if (en_rd_data) begin
         data_in <= bufm[rd_addr_data_out];
         rd_q.push_back(int'(rd_addr_data_out));
      end
      if (en_wr_S) sw_q.push_back(int'({wr_addr_S, wr_data_S}));
      if (en_wr_N) nw_q.push_back(int'({wr_addr_N, wr_data_N}));
      if (int'(en_rd_data) + int'(en_wr_S) + int'(en_wr_N) > 1) overlap++;
   end

   task automatic run_stp(input int a, input int n, input int ptr, input int raise_at,
                          input bit noisy, input string tag);
      int lat, exp_lat, rb, sb, nb, ob, extra, sum, p;
      bit err, ok;
      logic [31:0] exp_status;
      int exp_upd;
      err = (n > 10);
      rb = rd_q.size(); sb = sw_q.size(); nb = nw_q.size(); ob = overlap;
      @(posedge clk); #1;
      A = 3'(a); N_in = 5'(n); rd_addr_data = PW'(ptr); start_stp = 1'b1;
      if (raise_at == 0) data_count = 11'(n + 1 + int'($urandom_range(0, 20)));
      else               data_count = 11'($urandom_range(0, n));
      @(posedge clk); #1;
      start_stp = 1'b0; lat = 1;
      while (!done_stp && lat < 400) begin
         if (lat == raise_at) data_count = 11'(n + 1);
         if (noisy) begin
            start_stp = 1'($urandom_range(0, 1));
            A = 3'($urandom);
            N_in = 5'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      start_stp = 1'b0;
      extra = (raise_at > 2) ? raise_at - 2 : 0;
      exp_lat = err ? 2 : 2 * n + 6 + extra;
      sum = 0;
      for (int i = 0; i <= n && !err; i++) sum += int'(bufm[(ptr + i) % BS]);
`ifdef STP_CHECKSUM_EN
      exp_status = err ? 32'd1 : {16'(sum), 16'h0000};
`else
      exp_status = err ? 32'd1 : 32'd0;
`endif
      exp_upd = err ? ptr : (ptr + n + 1) % BS;

      n_checks++;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat); end
      n_checks++;
      if (status !== exp_status) begin n_fail++; $display("FAIL %s status: got %h expected %h", tag, status, exp_status); end
      n_checks++;
      if (int'(rd_addr_data_updated) !== exp_upd) begin n_fail++; $display("FAIL %s rd_ptr_updated: got %0d expected %0d", tag, rd_addr_data_updated, exp_upd); end

      ok = (rd_q.size() - rb == (err ? 0 : n + 1));
      for (int i = 0; ok && i <= n && !err; i++) if (rd_q[rb + i] != (ptr + i) % BS) ok = 0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s read_addrs: got %0d reads expected %0d from %0d", tag, rd_q.size() - rb, err ? 0 : n + 1, ptr); end

      ok = (sw_q.size() - sb == (err ? 0 : n + 1));
      for (int i = 0; ok && i <= n && !err; i++) begin
         p = int'({7'(a * 11 + i), bufm[(ptr + i) % BS]});
         if (sw_q[sb + i] != p) ok = 0;
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s s_writes: got %0d writes expected %0d at base %0d", tag, sw_q.size() - sb, err ? 0 : n + 1, a * 11); end

      ok = (nw_q.size() - nb == (err ? 0 : 1));
      if (ok && !err) ok = (nw_q[nb] == int'({3'(a), 5'(n)}));
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL %s n_write: got %0d writes expected %0d (A=%0d N=%0d)", tag, nw_q.size() - nb, err ? 0 : 1, a, n); end

      n_checks++;
      if (overlap - ob !== 0) begin n_fail++; $display("FAIL %s enable_overlap: got %0d expected 0", tag, overlap - ob); end

      @(posedge clk); #1;
      n_checks++;
      if ({done_stp, rd_addr_data_updated} !== {1'b0, PW'(exp_upd)}) begin
         n_fail++; $display("FAIL %s after_done: got done=%b ptr=%0d expected done=0 ptr=%0d", tag, done_stp, rd_addr_data_updated, exp_upd);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_instr = 1'b1; start_stp = 1'b0; A = '0; N_in = '0;
      rd_addr_data = 10'd321; data_count = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({en_rd_data, rd_addr_data_out, en_wr_S, wr_addr_S, wr_data_S, en_wr_N, wr_addr_N, wr_data_N, done_stp, status} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got en_rd=%b en_s=%b en_n=%b done=%b status=%h expected all zero", en_rd_data, en_wr_S, en_wr_N, done_stp, status);
      end
      n_checks++;
      if (rd_addr_data_updated !== 10'd321) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 321", rd_addr_data_updated); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bufm[0] = 16'd3; bufm[1] = 16'd4; bufm[2] = 16'd2; bufm[3] = 16'd1;
      run_stp(0, 3, 0, 0, 0, "basic");
   endtask

   task automatic test_max_degree();
      for (int i = 0; i < 11; i++) bufm[500 + i] = 16'(i + 1);
      run_stp(7, 10, 500, 0, 0, "max_degree");
   endtask

   task automatic test_invalid_n();
      run_stp(2, 11, 77, 0, 0, "invalid_n11");
      run_stp(int'($urandom_range(0, 7)), int'($urandom_range(12, 31)), int'($urandom_range(0, BS - 1)), 0, 1, "invalid_nrand");
   endtask

   task automatic test_wrap_wait();
      bufm[1022] = 16'($urandom); bufm[1023] = 16'($urandom); bufm[0] = 16'($urandom);
      run_stp(4, 2, 1022, 7, 0, "wrap_wait");
   endtask

   task automatic test_instr_reset();
      int k, sb, nb;
      sb = sw_q.size(); nb = nw_q.size();
      @(posedge clk); #1;
      A = 3'd3; N_in = 5'd3; rd_addr_data = 10'd100; data_count = 11'd4; start_stp = 1'b1;
      @(posedge clk); #1;
      start_stp = 1'b0; k = 0;
      while (!(en_wr_S && wr_addr_S == 7'd34) && k < 50) begin @(posedge clk); #1; k++; end
      n_checks++;
      if (k >= 50) begin n_fail++; $display("FAIL ireset_reach: got timeout expected write to S[34]"); end
      rst_instr = 1'b0; rd_addr_data = 10'd555;
      @(posedge clk); #1;
      n_checks++;
      if ({en_rd_data, rd_addr_data_out, en_wr_S, wr_addr_S, wr_data_S, en_wr_N, wr_addr_N, wr_data_N, done_stp, status} !== '0) begin
         n_fail++; $display("FAIL ireset_outputs: got en_rd=%b en_s=%b en_n=%b done=%b expected all zero", en_rd_data, en_wr_S, en_wr_N, done_stp);
      end
      n_checks++;
      if (rd_addr_data_updated !== 10'd555) begin n_fail++; $display("FAIL ireset_ptr: got %0d expected 555", rd_addr_data_updated); end
      rst_instr = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if ((sw_q.size() - sb != 2) || (nw_q.size() - nb != 0) || done_stp) begin
         n_fail++; $display("FAIL ireset_writes: got S=%0d N=%0d done=%b expected S=2 N=0 done=0", sw_q.size() - sb, nw_q.size() - nb, done_stp);
      end
      run_stp(3, 3, 200, 0, 0, "ireset_restart");
   endtask

   task automatic test_checksum();
      bufm[300] = 16'hFFFF; bufm[301] = 16'h0002;
      run_stp(5, 1, 300, 0, 0, "checksum");
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 3; t++) begin
         int p;
         p = int'($urandom_range(0, BS - 1));
         for (int i = 0; i < 11; i++) bufm[(p + i) % BS] = 16'($urandom);
         run_stp(t, t + 1, p, 0, 0, "back_to_back");
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         int p, n;
         p = (t % 4 == 0) ? int'($urandom_range(BS - 6, BS - 1)) : int'($urandom_range(0, BS - 1));
         n = int'($urandom_range(0, 12));
         for (int i = 0; i < 11; i++) bufm[(p + i) % BS] = 16'($urandom);
         run_stp(int'($urandom_range(0, 7)), n, p, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      for (int i = 0; i < BS; i++) bufm[i] = 16'($urandom);
      test_reset();
      test_basic();
      test_max_degree();
      test_invalid_n();
      test_wrap_wait();
      test_instr_reset();
      test_checksum();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
